// File: rtl/trap_ctrl.sv
// Execute-stage trap controller: arbitrates memory/breakpoint exceptions, captures
// mepc/mcause/mtval, flushes the pipeline and redirects fetch (also handles mret).
module trap_ctrl #(
  parameter int             N            = 64,
  parameter logic [N-1:0]   MTVEC_RESET  = '0,
  parameter int             FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          valid_E,
  input  logic          stall_E,
  input  logic [N-1:0]  pc_E,
  input  logic [N-1:0]  DM_addr,
  input  logic [6:0]    exceptSignal,
  input  logic          mret_E,
  input  logic          csr_we,
  input  logic [11:0]   csr_addr,
  input  logic [N-1:0]  csr_wdata,
  output logic [N-1:0]  csr_rdata,
  output logic          flush_o,
  output logic          redirect_o,
  output logic [N-1:0]  redirect_pc,
  output logic          trap_busy
);

  // state | meaning
  // IDLE  | waiting for a trap or mret in E
  // REDIR | one-cycle fetch redirect, pipeline flushed
  // FLUSH | remaining flush cycles counted down
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REDIR = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);

  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MTVAL    = 12'h343;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flush_q, flush_d;
  logic          redirect_q, redirect_d;
  logic          busy_q, busy_d;
  logic [N-1:0]  redirect_pc_q, redirect_pc_d;
  logic [N-1:0]  mtvec_q, mtvec_d;
  logic [N-1:0]  mscratch_q, mscratch_d;
  logic [N-1:0]  mepc_q, mepc_d;
  logic [N-1:0]  mcause_q, mcause_d;
  logic [N-1:0]  mtval_q, mtval_d;

  logic          any_exc;
  logic          take;
  logic          ret;
  logic [4:0]    cause_code;

  assign any_exc = |exceptSignal;
  assign take    = valid_E & ~stall_E & any_exc & (state_q == IDLE);
  assign ret     = valid_E & ~stall_E & mret_E & ~any_exc & (state_q == IDLE);

  // Fixed priority: breakpoint, then the misaligns, then page faults, then access faults.
  always_comb begin
    cause_code = 5'd0;
    if      (exceptSignal[6]) cause_code = 5'd3;
    else if (exceptSignal[2]) cause_code = 5'd6;
    else if (exceptSignal[0]) cause_code = 5'd4;
    else if (exceptSignal[5]) cause_code = 5'd15;
    else if (exceptSignal[4]) cause_code = 5'd13;
    else if (exceptSignal[3]) cause_code = 5'd7;
    else if (exceptSignal[1]) cause_code = 5'd5;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (take || ret) begin
          state_d       = REDIR;
          cnt_d         = CNT_LOAD;
          redirect_pc_d = take ? {mtvec_q[N-1:2], 2'b00} : mepc_q;
        end
      end
      REDIR: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    flush_d    = (state_d != IDLE);
    busy_d     = (state_d != IDLE);
    redirect_d = (state_d == REDIR);
  end

  // Trap capture overrides a same-edge software write to mepc/mcause/mtval.
  always_comb begin
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    if (csr_we) begin
      case (csr_addr)
        A_MTVEC:    mtvec_d    = csr_wdata;
        A_MSCRATCH: mscratch_d = csr_wdata;
        A_MEPC:     mepc_d     = csr_wdata;
        A_MCAUSE:   mcause_d   = {1'b0, csr_wdata[N-2:0]};
        A_MTVAL:    mtval_d    = csr_wdata;
        default: ;
      endcase
    end
    if (take) begin
      mepc_d   = pc_E;
      mcause_d = {{(N-5){1'b0}}, cause_code};
      mtval_d  = exceptSignal[6] ? pc_E : DM_addr;
    end
  end

  always_comb begin
    case (csr_addr)
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MTVAL:    csr_rdata = mtval_q;
      default:    csr_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      flush_q       <= 1'b0;
      redirect_q    <= 1'b0;
      busy_q        <= 1'b0;
      redirect_pc_q <= '0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      flush_q       <= flush_d;
      redirect_q    <= redirect_d;
      busy_q        <= busy_d;
      redirect_pc_q <= redirect_pc_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
    end
  end

  assign flush_o     = flush_q;
  assign redirect_o  = redirect_q;
  assign trap_busy   = busy_q;
  assign redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus randomized traffic
// compared against a behavioural model of the trap CSRs and flush timeline.
module tb_trap_ctrl;
  localparam int          N       = 64;
  localparam int          FC      = 2;
  localparam logic [63:0] MTV_RST = 64'h0000_0000_8000_0000;
  localparam int PR_BIT [7]  = '{6, 2, 0, 5, 4, 3, 1};
  localparam int PR_CODE [7] = '{3, 6, 4, 15, 13, 7, 5};
  localparam logic [11:0] ADDRS [6] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h300};

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_E, stall_E, mret_E, csr_we;
  logic [N-1:0]  pc_E, DM_addr, csr_wdata, csr_rdata, redirect_pc;
  logic [6:0]    exceptSignal;
  logic [11:0]   csr_addr;
  logic          flush_o, redirect_o, trap_busy;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;

  trap_ctrl #(.N(N), .MTVEC_RESET(MTV_RST), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .reset(reset), .valid_E(valid_E), .stall_E(stall_E), .pc_E(pc_E),
    .DM_addr(DM_addr), .exceptSignal(exceptSignal), .mret_E(mret_E), .csr_we(csr_we),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .flush_o(flush_o),
    .redirect_o(redirect_o), .redirect_pc(redirect_pc), .trap_busy(trap_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  function automatic logic [63:0] cause_of(input logic [6:0] e);
    for (int i = 0; i < 7; i++)
      if (e[PR_BIT[i]]) return 64'(PR_CODE[i]);
    return 64'd0;
  endfunction

  function automatic logic [63:0] model_csr(input logic [11:0] a);
    case (a)
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      default: return 64'd0;
    endcase
  endfunction

  task automatic quiet();
    valid_E = 0; stall_E = 0; mret_E = 0; exceptSignal = '0; csr_we = 0;
    csr_wdata = '0; csr_addr = 12'h000;
  endtask

  task automatic model_reset();
    m_mtvec = MTV_RST; m_mscratch = '0; m_mepc = '0; m_mcause = '0; m_mtval = '0;
  endtask

  task automatic check_csrs(input string tag);
    for (int i = 0; i < 6; i++) begin
      csr_addr = ADDRS[i];
      #1;
      vectors++;
      if (csr_rdata !== model_csr(ADDRS[i])) begin
        miscompares++;
        $display("FAIL %s csr[%h]: got %h, required %h", tag, ADDRS[i], csr_rdata, model_csr(ADDRS[i]));
      end
    end
    csr_addr = 12'h000;
  endtask

  // Expected timeline after an accepted trap/mret: redirect for one cycle, flush for FC cycles.
  task automatic observe_event(input string tag, input logic [63:0] exp_pc, input bit junk);
    for (int k = 1; k <= FC + 1; k++) begin
      vectors++;
      if (redirect_o !== (k == 1) || flush_o !== (k <= FC) || trap_busy !== (k <= FC)) begin
        miscompares++;
        $display("FAIL %s timeline k=%0d: got redir=%b flush=%b busy=%b, required %b %b %b",
                 tag, k, redirect_o, flush_o, trap_busy, k == 1, k <= FC, k <= FC);
      end
      if (k == 1) begin
        vectors++;
        if (redirect_pc !== exp_pc) begin
          miscompares++;
          $display("FAIL %s redirect_pc: got %h, required %h", tag, redirect_pc, exp_pc);
        end
      end
      if (k <= FC) begin
        if (junk) begin
          valid_E = 1; exceptSignal = 7'($urandom); mret_E = 1'($urandom);
          pc_E = {$urandom, $urandom}; DM_addr = {$urandom, $urandom}; csr_we = 0;
        end else quiet();
        @(posedge clk); #1;
      end
    end
    quiet();
  endtask

  task automatic step_event(input string tag, input logic [6:0] exc, input logic [63:0] pc,
                            input logic [63:0] addr, input bit mret, input bit vld, input bit stl,
                            input bit we, input logic [11:0] waddr, input logic [63:0] wdata,
                            input bit junk);
    bit take, ret;
    logic [63:0] exp_pc;
    exceptSignal = exc; pc_E = pc; DM_addr = addr; mret_E = mret; valid_E = vld; stall_E = stl;
    csr_we = we; csr_addr = waddr; csr_wdata = wdata;
    take   = vld && !stl && (exc != 0);
    ret    = vld && !stl && mret && (exc == 0);
    exp_pc = take ? {m_mtvec[63:2], 2'b00} : m_mepc;
    @(posedge clk); #1;
    if (we) begin
      case (waddr)
        12'h305: m_mtvec = wdata;
        12'h340: m_mscratch = wdata;
        12'h341: if (!take) m_mepc = wdata;
        12'h342: if (!take) m_mcause = {1'b0, wdata[62:0]};
        12'h343: if (!take) m_mtval = wdata;
        default: ;
      endcase
    end
    if (take) begin
      m_mepc = pc; m_mcause = cause_of(exc); m_mtval = exc[6] ? pc : addr;
    end
    quiet();
    if (take || ret) observe_event(tag, exp_pc, junk);
    else begin
      vectors++;
      if (flush_o !== 0 || redirect_o !== 0 || trap_busy !== 0) begin
        miscompares++;
        $display("FAIL %s idle: got flush=%b redir=%b busy=%b, required 0 0 0",
                 tag, flush_o, redirect_o, trap_busy);
      end
    end
    check_csrs(tag);
  endtask

  task automatic test_reset();
    quiet(); pc_E = '0; DM_addr = '0; reset = 1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    vectors++;
    if (flush_o !== 0 || redirect_o !== 0 || trap_busy !== 0 || redirect_pc !== '0) begin
      miscompares++;
      $display("FAIL reset outs: got flush=%b redir=%b busy=%b pc=%h, required all 0",
               flush_o, redirect_o, trap_busy, redirect_pc);
    end
    check_csrs("reset");
  endtask

  task automatic test_ld_misalign();
    step_event("ld_misalign", 7'b0000001, 64'h100, 64'h1003, 0, 1, 0, 0, 12'h0, '0, 0);
  endtask

  task automatic test_priority();
    step_event("prio_brk", 7'b1000101, 64'h140, 64'h2222, 0, 1, 0, 0, 12'h0, '0, 0);
    for (int i = 0; i < 10; i++)
      step_event("prio_rand", 7'($urandom_range(1, 127)), {$urandom, $urandom},
                 {$urandom, $urandom}, 1'($urandom), 1, 0, 0, 12'h0, '0, 0);
  endtask

  task automatic test_stall();
    step_event("novalid", 7'b0000100, 64'h300, 64'h3004, 0, 0, 0, 0, 12'h0, '0, 0);
    step_event("stalled", 7'b0000100, 64'h300, 64'h3004, 0, 1, 1, 0, 12'h0, '0, 0);
    step_event("unstall", 7'b0000100, 64'h300, 64'h3004, 0, 1, 0, 0, 12'h0, '0, 0);
  endtask

  task automatic test_mret();
    step_event("wr_mepc", 7'b0, 64'h0, 64'h0, 0, 0, 0, 1, 12'h341, 64'h200, 0);
    step_event("mret", 7'b0, 64'h400, 64'h0, 1, 1, 0, 0, 12'h0, '0, 0);
    step_event("mret_stall", 7'b0, 64'h400, 64'h0, 1, 1, 1, 0, 12'h0, '0, 0);
  endtask

  task automatic test_back_to_back();
    step_event("same_edge", 7'b0010000, 64'h500, 64'h5008, 0, 1, 0, 1, 12'h342, 64'hAA, 1);
    step_event("wr_mtvec", 7'b0, 64'h0, 64'h0, 0, 0, 0, 1, 12'h305, 64'h0000_0000_0000_9007, 0);
    step_event("masked_vec", 7'b0100000, 64'h600, 64'h6000, 0, 1, 0, 0, 12'h0, '0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [6:0] e;
      e = ($urandom_range(0, 1) == 0) ? 7'b0 : 7'($urandom);
      step_event("random", e, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                 1'($urandom), ADDRS[$urandom_range(0, 5)], {$urandom, $urandom},
                 1'($urandom));
    end
  endtask

  task automatic test_reset_mid_trap();
    step_event("pre_wr", 7'b0, 64'h0, 64'h0, 0, 0, 0, 1, 12'h340, 64'h1234, 0);
    exceptSignal = 7'b0001000; valid_E = 1; pc_E = 64'h700; DM_addr = 64'h7010;
    @(posedge clk); #1;
    quiet();
    @(posedge clk); #2;
    vectors++;
    if (flush_o !== 1 || trap_busy !== 1) begin
      miscompares++;
      $display("FAIL mid_trap pre: got flush=%b busy=%b, required 1 1", flush_o, trap_busy);
    end
    reset = 1;
    model_reset();
    #1;
    vectors++;
    if (flush_o !== 0 || trap_busy !== 0 || redirect_o !== 0 || redirect_pc !== '0) begin
      miscompares++;
      $display("FAIL mid_trap reset: got flush=%b busy=%b redir=%b pc=%h, required all 0",
               flush_o, trap_busy, redirect_o, redirect_pc);
    end
    check_csrs("mid_trap_reset");
    @(negedge clk); reset = 0;
    step_event("after_reset", 7'b0000010, 64'h800, 64'h8020, 0, 1, 0, 0, 12'h0, '0, 0);
  endtask

  initial begin
    test_reset();
    test_ld_misalign();
    test_priority();
    test_stall();
    test_mret();
    test_back_to_back();
    test_random();
    test_reset_mid_trap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
